// File: rtl/full_conv_engine.sv
`timescale 1ns/1ps
// Streaming multi-kernel 2-D convolution engine: raster pixels in, one result per
// kernel for every valid k x k window (stride 1, no padding).
module full_conv_engine #(
  parameter int N      = 7,
  parameter int nok    = 6,
  parameter int stride = 5,
  parameter int n      = 5,
  parameter int im     = 28,
  parameter int img    = im + stride - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N:0]            data,
  input  logic                  data_valid,
  input  logic signed [N:0]     ker [nok][stride*stride],
  input  logic [11:0]           img_len,
  input  logic [2:0]            ker_len,
  output logic                  data_request,
  output logic signed [2*N+1:0] out [nok],
  output logic                  finish,
  output logic                  valid,
  output logic [11:0]           valid_idx,
  output logic                  conv_fin
);

  localparam int W  = 2*N + 2;
  localparam int AW = (img > 1) ? $clog2(img) : 1;
  localparam int SW = (stride > 1) ? $clog2(stride) : 1;

  if (n < 1 || n > stride) begin : g_n_chk
    $error("nominal kernel side n must lie within 1..stride");
  end

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CALC, S_OUT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [11:0]         row_q, col_q, cnt_q, vidx_q;
  logic                eol_q, eoi_q;
  logic [N:0]          lb_q  [stride-1][img];
  logic [N:0]          win_q [stride][stride];
  logic signed [W-1:0] out_q [nok];
  logic signed [W-1:0] sum_d [nok];
  logic                accept, col_last, row_last, win_done;
  logic [11:0]         km1;
  logic [AW-1:0]       lb_addr;
  logic [SW-1:0]       woff;
  int                  k_i;

  function automatic logic signed [W-1:0] mac_term(input logic [N:0] pix,
                                                   input logic signed [N:0] tap);
    logic signed [W-1:0] p_ext, t_ext;
    p_ext = signed'({{(W-N-1){1'b0}}, pix});
    t_ext = W'(tap);
    return p_ext * t_ext;
  endfunction

  assign km1      = {9'd0, ker_len} - 12'd1;
  assign col_last = (col_q == img_len - 12'd1);
  assign row_last = (row_q == img_len - 12'd1);
  assign win_done = (row_q >= km1) && (col_q >= km1);
  assign accept   = (state_q == S_REQ) && data_valid;
  assign lb_addr  = col_q[AW-1:0];
  assign k_i      = {29'd0, ker_len};
  // The active k x k window sits in the bottom-right corner of the window register.
  assign woff     = SW'(stride) - SW'(ker_len);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (accept && win_done) state_d = S_CALC;
      S_CALC:  state_d = S_OUT;
      S_OUT:   state_d = eoi_q ? S_DONE : S_REQ;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      vidx_q  <= '0;
      eol_q   <= 1'b0;
      eoi_q   <= 1'b0;
      for (int j = 0; j < nok; j++) out_q[j] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        eol_q <= col_last;
        eoi_q <= col_last && row_last;
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 12'd1;
        end else begin
          col_q <= col_q + 12'd1;
        end
      end
      if (state_q == S_CALC) begin
        vidx_q <= cnt_q;
        for (int j = 0; j < nok; j++) out_q[j] <= sum_d[j];
      end
      if (state_q == S_OUT) cnt_q <= cnt_q + 12'd1;
    end
  end

  // Pixel capture: each accepted pixel shifts a fresh column into the window and
  // pushes the column history one row up in the line buffer.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < stride; r++) begin
        for (int c = 0; c < stride-1; c++) win_q[r][c] <= win_q[r][c+1];
      end
      for (int r = 0; r < stride-1; r++) win_q[r][stride-1] <= lb_q[r][lb_addr];
      win_q[stride-1][stride-1] <= data;
      for (int r = 0; r < stride-2; r++) lb_q[r][lb_addr] <= lb_q[r+1][lb_addr];
      lb_q[stride-2][lb_addr] <= data;
    end
  end

  // Multiply-accumulate over the window, wrapping at W bits.
  always_comb begin
    logic signed [W-1:0] acc;
    acc = '0;
    for (int j = 0; j < nok; j++) begin
      acc = '0;
      for (int r = 0; r < stride; r++) begin
        for (int c = 0; c < stride; c++) begin
          if (r < k_i && c < k_i)
            acc = acc + mac_term(win_q[woff + SW'(r)][woff + SW'(c)], ker[j][r*stride + c]);
        end
      end
      sum_d[j] = acc;
    end
  end

  assign out          = out_q;
  assign valid_idx    = vidx_q;
  assign data_request = (state_q == S_REQ);
  assign valid        = (state_q == S_OUT);
  assign finish       = (state_q == S_OUT) && eol_q;
  assign conv_fin     = (state_q == S_DONE);

endmodule

// File: tb/tb_full_conv_engine.sv
`timescale 1ns/1ps
// Scoreboard bench for full_conv_engine: expected window sums are computed from a
// stored copy of the image and queued as pixels are driven.
module tb_full_conv_engine;
  localparam int NOK = 6;
  localparam int KS  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        data;
  logic              data_valid;
  logic signed [7:0] kr [NOK][KS*KS];
  logic [11:0]       img_len;
  logic [2:0]        ker_len;
  logic              data_request, finish, valid, conv_fin;
  logic signed [15:0] dout [NOK];
  logic [11:0]       valid_idx;

  typedef struct packed {
    logic [NOK-1:0][15:0] o;
    logic [11:0]          idx;
    logic                 fin;
  } exp_t;

  exp_t        sbq[$];
  int          pix_mem [1024];
  logic [15:0] cap [NOK][1024];
  int          n_chk = 0;
  int          n_err = 0;
  int          vcnt = 0;
  int          fcnt = 0;
  logic        prev_v = 1'b0;
  int          tblc [9] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
  int          rscale [5] = '{1, 2, 3, 2, 1};

  always #5 clk = ~clk;

  full_conv_engine dut (
    .clk          (clk),
    .reset        (reset),
    .data         (data),
    .data_valid   (data_valid),
    .ker          (kr),
    .img_len      (img_len),
    .ker_len      (ker_len),
    .data_request (data_request),
    .out          (dout),
    .finish       (finish),
    .valid        (valid),
    .valid_idx    (valid_idx),
    .conv_fin     (conv_fin)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input int L, input int k, input int j,
                                        input int r0, input int c0);
    int acc;
    acc = 0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        acc += pix_mem[(r0+r)*L + c0 + c] * int'(kr[j][r*KS + c]);
    return acc[15:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      vcnt++;
      check_val("valid_gap", {31'd0, prev_v}, 32'd0);
      if (sbq.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        for (int j = 0; j < NOK; j++) begin
          check_val($sformatf("out%0d", j), {16'd0, $unsigned(dout[j])}, {16'd0, e.o[j]});
          cap[j][valid_idx[9:0]] = dout[j];
        end
        check_val("valid_idx", {20'd0, valid_idx}, {20'd0, e.idx});
        check_val("finish", {31'd0, finish}, {31'd0, e.fin});
      end
    end
    if (finish) fcnt++;
    prev_v = valid;
  end

  task automatic check_idle(input string pfx);
    check_val({pfx, "_req"},  {31'd0, data_request}, 0);
    check_val({pfx, "_valid"}, {31'd0, valid}, 0);
    check_val({pfx, "_finish"}, {31'd0, finish}, 0);
    check_val({pfx, "_conv_fin"}, {31'd0, conv_fin}, 0);
    check_val({pfx, "_vidx"}, {20'd0, valid_idx}, 0);
    for (int j = 0; j < NOK; j++)
      check_val($sformatf("%s_out%0d", pfx, j), {16'd0, $unsigned(dout[j])}, 0);
  endtask

  task automatic start(input int L, input int k);
    img_len    = 12'(L);
    ker_len    = 3'(k);
    reset      = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    sbq.delete();
    repeat (3) @(negedge clk);
    check_idle("rst");
    reset = 1'b1;
  endtask

  task automatic rand_kernels();
    for (int j = 0; j < NOK; j++)
      for (int i = 0; i < KS*KS; i++) kr[j][i] = 8'($urandom);
  endtask

  task automatic run_img(input int L, input int k, input bit gaps, input int npix);
    int   v0, f0, waitc, r, c;
    exp_t e;
    v0 = vcnt;
    f0 = fcnt;
    for (int p = 0; p < npix; p++) begin
      r = p / L;
      c = p % L;
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          data = 8'($urandom);
          data_valid = !data_request;
        end
      end
      @(negedge clk);
      waitc = 0;
      while (!data_request && waitc < 40) begin
        data = 8'($urandom);
        data_valid = gaps;
        @(negedge clk);
        waitc++;
      end
      if (!data_request) begin
        check_val("req_timeout", 32'd0, 32'd1);
        data_valid = 1'b0;
        return;
      end
      data = 8'(pix_mem[p]);
      data_valid = 1'b1;
      if (r >= k-1 && c >= k-1) begin
        for (int j = 0; j < NOK; j++) e.o[j] = model(L, k, j, r-k+1, c-k+1);
        e.idx = 12'((r-k+1)*(L-k+1) + (c-k+1));
        e.fin = (c == L-1);
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    data_valid = 1'b0;
    if (npix == L*L) begin
      waitc = 0;
      while (!conv_fin && waitc < 20) begin
        @(negedge clk);
        waitc++;
      end
      check_val("conv_fin", {31'd0, conv_fin}, 1);
      repeat (3) @(negedge clk);
      check_val("conv_fin_sticky", {31'd0, conv_fin}, 1);
      check_val("req_done", {31'd0, data_request}, 0);
      check_val("valid_cnt", vcnt - v0, (L-k+1)*(L-k+1));
      check_val("finish_cnt", fcnt - f0, L-k+1);
      check_val("sb_empty", sbq.size(), 0);
    end
  endtask

  task automatic setup_a();
    for (int i = 0; i < 1024; i++) pix_mem[i] = 1;
    rand_kernels();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        kr[0][r*KS + c] = 8'sd1;
        kr[1][r*KS + c] = 8'((r == 1 ? 2 : 1) * (c == 1 ? 2 : 1));
      end
  endtask

  initial begin
    reset = 1'b0; data_valid = 1'b0; data = '0; img_len = '0; ker_len = '0;
    rand_kernels();

    setup_a();
    start(32, 3);
    run_img(32, 3, 1'b0, 1024);
    check_val("A_out0_first", {16'd0, cap[0][0]}, 9);
    check_val("A_out1_last", {16'd0, cap[1][899]}, 16);

    for (int i = 0; i < 1024; i++) pix_mem[i] = 7;
    rand_kernels();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) kr[2][r*KS + c] = 8'(rscale[r] * (2 - c));
    start(32, 5);
    run_img(32, 5, 1'b0, 1024);
    check_val("B_out2_first", {16'd0, cap[2][0]}, 0);
    check_val("B_out2_last", {16'd0, cap[2][783]}, 0);

    for (int i = 0; i < 25; i++) pix_mem[i] = i;
    rand_kernels();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) kr[0][r*KS + c] = 8'sd1;
    start(5, 3);
    run_img(5, 3, 1'b0, 25);
    for (int i = 0; i < 9; i++)
      check_val($sformatf("C_out0_%0d", i), {16'd0, cap[0][i]}, tblc[i]);

    for (int i = 0; i < 36; i++) pix_mem[i] = 10;
    rand_kernels();
    for (int i = 0; i < KS*KS; i++) kr[0][i] = 8'hFF;
    start(6, 3);
    run_img(6, 3, 1'b0, 36);
    check_val("D_out0_neg", {16'd0, cap[0][0]}, 32'h0000FFA6);
    check_val("D_out0_last", {16'd0, cap[0][15]}, 32'h0000FFA6);

    for (int i = 0; i < 144; i++) pix_mem[i] = $urandom_range(0, 255);
    rand_kernels();
    start(12, 4);
    run_img(12, 4, 1'b1, 144);

    for (int i = 0; i < 4; i++) pix_mem[i] = $urandom_range(0, 255);
    rand_kernels();
    start(2, 2);
    run_img(2, 2, 1'b1, 4);

    for (int i = 0; i < 9; i++) pix_mem[i] = $urandom_range(0, 255);
    start(3, 1);
    run_img(3, 1, 1'b0, 9);

    for (int i = 0; i < 25; i++) pix_mem[i] = $urandom_range(0, 255);
    start(5, 5);
    run_img(5, 5, 1'b1, 25);

    setup_a();
    start(32, 3);
    run_img(32, 3, 1'b0, 500);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_idle("midrst");
    sbq.delete();
    @(negedge clk);
    start(32, 3);
    run_img(32, 3, 1'b0, 1024);
    check_val("G_out0", {16'd0, cap[0][450]}, 9);
    check_val("G_out1", {16'd0, cap[1][450]}, 16);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
